// File: rtl/spc_pcx_req_ctl_pkg.sv
// Shared constants and FSM encoding for the core-side PCX request issuer.
// Imported by the interface, the request FIFO and the top.
package spc_pcx_req_ctl_pkg;

  localparam int PCX_WIDTH   = 124;
  localparam int PCX_NDEST   = 5;
  localparam int PCX_CREDITS = 2;
  localparam int PCX_DEPTH   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    ATOM2 = 1'b1
  } pcx_st_e;

endpackage

// File: rtl/spc_pcx_req_ctl_if.sv
// LSU enqueue side plus PCX request/grant side of the request issuer.
// master: the issuer itself; slave: the LSU/PCX environment around it.
interface spc_pcx_req_ctl_if
  import spc_pcx_req_ctl_pkg::*;
#(
  parameter int PKT_W = PCX_WIDTH,
  parameter int NDEST = PCX_NDEST
);

  logic             lsu_pcx_vld;
  logic [NDEST-1:0] lsu_pcx_dest;
  logic             lsu_pcx_atom;
  logic [PKT_W-1:0] lsu_pcx_data;
  logic             pcx_lsu_rdy;
  logic [NDEST-1:0] pcx_spc_grant_pa;
  logic             pcx_stall_pq;
  logic [NDEST-1:0] spc_pcx_req_pq;
  logic             spc_pcx_atom_pq;
  logic [PKT_W-1:0] spc_pcx_data_pa;
  logic             pcx_credit_err;

  modport master (
    input  lsu_pcx_vld,
    input  lsu_pcx_dest,
    input  lsu_pcx_atom,
    input  lsu_pcx_data,
    output pcx_lsu_rdy,
    input  pcx_spc_grant_pa,
    input  pcx_stall_pq,
    output spc_pcx_req_pq,
    output spc_pcx_atom_pq,
    output spc_pcx_data_pa,
    output pcx_credit_err
  );

  modport slave (
    output lsu_pcx_vld,
    output lsu_pcx_dest,
    output lsu_pcx_atom,
    output lsu_pcx_data,
    input  pcx_lsu_rdy,
    output pcx_spc_grant_pa,
    output pcx_stall_pq,
    input  spc_pcx_req_pq,
    input  spc_pcx_atom_pq,
    input  spc_pcx_data_pa,
    input  pcx_credit_err
  );

endinterface

// File: rtl/pcx_req_fifo.sv
// In-order request FIFO: DEPTH entries of W bits, sync active-low reset.
// Ports: push/wdata in, pop in; head, head/next valid and count out.
module pcx_req_fifo
  import spc_pcx_req_ctl_pkg::*;
#(
  parameter int W     = 1 + PCX_NDEST + PCX_WIDTH,
  parameter int DEPTH = PCX_DEPTH,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_l_i,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic          head_vld_o,
  output logic          nxt_vld_o,
  output logic [CW-1:0] cnt_o
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push_i && (cnt_q != FULL);
  assign do_pop  = pop_i && (cnt_q != '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (!rst_l_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  assign head_o     = mem_q[rd_q];
  assign head_vld_o = cnt_q != '0;
  assign nxt_vld_o  = cnt_q >= CW'(2);
  assign cnt_o      = cnt_q;

endmodule

// File: rtl/spc_pcx_req_ctl.sv
// Core-side PCX request issuer: FIFO, per-dest credits, atomic-pair FSM.
// Ports: rclk, rst_l (sync, active low), bus (LSU enqueue + PCX req/grant).
module spc_pcx_req_ctl
  import spc_pcx_req_ctl_pkg::*;
#(
  parameter int PKT_W   = PCX_WIDTH,
  parameter int NDEST   = PCX_NDEST,
  parameter int DEPTH   = PCX_DEPTH,
  parameter int CREDITS = PCX_CREDITS
) (
  input logic            rclk,
  input logic            rst_l,
  spc_pcx_req_ctl_if.master bus
);

  localparam int EW = 1 + NDEST + PKT_W;
  localparam int CW = $clog2(CREDITS + 1);
  localparam int QW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CMAX = CW'(CREDITS);

  logic [EW-1:0]    head;
  logic             head_vld;
  logic             nxt_vld;
  logic [QW-1:0]    cnt;
  logic             h_atom;
  logic [NDEST-1:0] h_dest;
  logic [PKT_W-1:0] h_data;
  logic             rdy;
  logic             push;

  pcx_st_e          state_q, state_d;
  logic [NDEST-1:0] adest_q, adest_d;
  logic [PKT_W-1:0] data_q, data_d;
  logic             err_q, err_d;
  logic [CW-1:0]    outst_q [NDEST];
  logic [CW-1:0]    outst_d [NDEST];

  logic [NDEST-1:0] cr_ok;
  logic [NDEST-1:0] cr_zero;
  logic             dest_ok;
  logic             dest_idle;
  logic             can_go;
  logic             issue;
  logic [NDEST-1:0] req;
  logic             atom;
  logic             mis;
  logic             gerr;

  assign rdy  = cnt < QW'(DEPTH);
  assign push = bus.lsu_pcx_vld && rdy;

  pcx_req_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (rclk),
    .rst_l_i    (rst_l),
    .push_i     (push),
    .wdata_i    ({bus.lsu_pcx_atom, bus.lsu_pcx_dest,
                  bus.lsu_pcx_data}),
    .pop_i      (issue),
    .head_o     (head),
    .head_vld_o (head_vld),
    .nxt_vld_o  (nxt_vld),
    .cnt_o      (cnt)
  );

  assign h_atom = head[EW-1];
  assign h_dest = head[PKT_W +: NDEST];
  assign h_data = head[PKT_W-1:0];

  always_comb begin
    cr_ok   = '0;
    cr_zero = '0;
    for (int d = 0; d < NDEST; d++) begin
      cr_ok[d]   = outst_q[d] < CMAX;
      cr_zero[d] = outst_q[d] == '0;
    end
  end

  // Only the bits set in the one-hot dest take part in the check.
  assign dest_ok   = &(cr_ok | ~h_dest);
  assign dest_idle = &(cr_zero | ~h_dest);

  // An atomic first half waits for its partner and an idle destination,
  // so the second half can go out unconditionally next cycle.
  assign can_go = head_vld && !bus.pcx_stall_pq && dest_ok &&
                  (!h_atom || (nxt_vld && dest_idle));

  always_comb begin
    state_d = state_q;
    adest_d = adest_q;
    issue   = 1'b0;
    req     = '0;
    atom    = 1'b0;
    mis     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (can_go) begin
          issue = 1'b1;
          req   = h_dest;
          atom  = h_atom;
          if (h_atom) begin
            state_d = ATOM2;
            adest_d = h_dest;
          end
        end
      end
      ATOM2: begin
        state_d = IDLE;
        if (head_vld) begin
          issue = 1'b1;
          req   = adest_q;
          mis   = h_dest != adest_q;
        end
      end
    endcase
  end

  always_comb begin
    gerr = 1'b0;
    for (int d = 0; d < NDEST; d++) begin
      outst_d[d] = outst_q[d];
      case ({req[d], bus.pcx_spc_grant_pa[d]})
        2'b10: outst_d[d] = outst_q[d] + CW'(1);
        2'b01: begin
          if (cr_zero[d]) gerr = 1'b1;
          else outst_d[d] = outst_q[d] - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign err_d  = err_q | gerr | mis;
  assign data_d = issue ? h_data : '0;

  always_ff @(posedge rclk) begin
    if (!rst_l) begin
      state_q <= IDLE;
      adest_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      for (int d = 0; d < NDEST; d++) outst_q[d] <= '0;
    end else begin
      state_q <= state_d;
      adest_q <= adest_d;
      data_q  <= data_d;
      err_q   <= err_d;
      for (int d = 0; d < NDEST; d++) outst_q[d] <= outst_d[d];
    end
  end

  assign bus.pcx_lsu_rdy     = rdy;
  assign bus.spc_pcx_req_pq  = req;
  assign bus.spc_pcx_atom_pq = atom;
  assign bus.spc_pcx_data_pa = data_q;
  assign bus.pcx_credit_err  = err_q;

endmodule

// File: tb/tb_spc_pcx_req_ctl.sv
// Self-checking bench for spc_pcx_req_ctl: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_spc_pcx_req_ctl;

  localparam int PW = 124;
  localparam int ND = 5;
  localparam int DP = 4;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  spc_pcx_req_ctl_if #(.PKT_W(PW), .NDEST(ND)) bus ();

  spc_pcx_req_ctl #(
    .PKT_W   (PW),
    .NDEST   (ND),
    .DEPTH   (DP),
    .CREDITS (2)
  ) dut (
    .rclk  (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  typedef struct {
    logic [ND-1:0] dest;
    logic          atom;
    logic [PW-1:0] data;
  } pkt_t;

  pkt_t          mq[$];
  int            mout[ND];
  bit            mpend;
  logic [ND-1:0] mpdest;
  logic [PW-1:0] mdata;
  bit            merr;
  logic [ND-1:0] e_req;
  logic          e_atom;
  bit            e_iss;

  int checks = 0;
  int failures = 0;

  function automatic void m_reset();
    mq.delete();
    for (int d = 0; d < ND; d++) mout[d] = 0;
    mpend = 0;
    mpdest = '0;
    mdata = '0;
    merr = 0;
  endfunction

  function automatic int oh2i(logic [ND-1:0] v);
    for (int d = 0; d < ND; d++) if (v[d]) return d;
    return 0;
  endfunction

  // Expected request for the current cycle from queue + credit state.
  function automatic void m_eval();
    int i;
    e_req = '0;
    e_atom = 1'b0;
    e_iss = 0;
    if (mpend) begin
      e_iss = 1;
      e_req = mpdest;
    end else if (mq.size() > 0 && !bus.pcx_stall_pq) begin
      i = oh2i(mq[0].dest);
      if (mout[i] < 2 &&
          (!mq[0].atom || (mq.size() >= 2 && mout[i] == 0))) begin
        e_iss = 1;
        e_req = mq[0].dest;
        e_atom = mq[0].atom;
      end
    end
  endfunction

  // Applies the clock edge to the model.
  function automatic void m_commit();
    bit   acc;
    pkt_t np;
    acc = bus.lsu_pcx_vld && (mq.size() < DP);
    np.dest = bus.lsu_pcx_dest;
    np.atom = bus.lsu_pcx_atom;
    np.data = bus.lsu_pcx_data;
    if (!rst_l) begin
      m_reset();
      return;
    end
    for (int d = 0; d < ND; d++) begin
      if (bus.pcx_spc_grant_pa[d] && !e_req[d] && mout[d] == 0)
        merr = 1;
      else
        mout[d] = mout[d] + int'(e_req[d])
                  - int'(bus.pcx_spc_grant_pa[d]);
    end
    if (e_iss) begin
      if (mpend && mq[0].dest != mpdest) merr = 1;
      mdata = mq[0].data;
      mpend = !mpend && mq[0].atom;
      if (mpend) mpdest = mq[0].dest;
      void'(mq.pop_front());
    end else begin
      mdata = '0;
    end
    if (acc) mq.push_back(np);
  endfunction

  task automatic idle_in();
    bus.lsu_pcx_vld = 1'b0;
    bus.lsu_pcx_dest = '0;
    bus.lsu_pcx_atom = 1'b0;
    bus.lsu_pcx_data = '0;
    bus.pcx_spc_grant_pa = '0;
    bus.pcx_stall_pq = 1'b0;
  endtask

  task automatic put(logic [ND-1:0] d, logic a, logic [PW-1:0] v);
    bus.lsu_pcx_vld = 1'b1;
    bus.lsu_pcx_dest = d;
    bus.lsu_pcx_atom = a;
    bus.lsu_pcx_data = v;
  endtask

  task automatic settle();
    @(negedge clk);
    m_eval();
  endtask

  task automatic advance();
    m_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_l = 1'b0;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    rst_l = 1'b1;
    m_reset();
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    idle_in();
    put(5'b00001, 1'b0, 124'h5A);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (bus.spc_pcx_req_pq !== 5'b0 || bus.spc_pcx_atom_pq !== 1'b0) begin
        failures++;
        $display("FAIL rst_req c=%0d got=%b/%b exp=0", c,
                 bus.spc_pcx_req_pq, bus.spc_pcx_atom_pq);
      end
      checks++;
      if (bus.spc_pcx_data_pa !== '0 || bus.pcx_credit_err !== 1'b0) begin
        failures++;
        $display("FAIL rst_data c=%0d got=%h err=%b exp=0", c,
                 bus.spc_pcx_data_pa, bus.pcx_credit_err);
      end
    end
    @(posedge clk);
    #1;
    rst_l = 1'b1;
    idle_in();
    m_reset();
    for (int c = 0; c < 2; c++) begin
      settle();
      checks++;
      if (bus.pcx_lsu_rdy !== 1'b1 || bus.spc_pcx_req_pq !== 5'b0) begin
        failures++;
        $display("FAIL rst_rel c=%0d rdy=%b req=%b exp rdy=1 req=0", c,
                 bus.pcx_lsu_rdy, bus.spc_pcx_req_pq);
      end
      advance();
    end
  endtask

  task automatic test_single();
    do_reset();
    put(5'b00001, 1'b0, 124'hA5);
    settle();
    advance();
    idle_in();
    settle();
    checks++;
    if (bus.spc_pcx_req_pq !== 5'b00001 || bus.spc_pcx_atom_pq !== 1'b0) begin
      failures++;
      $display("FAIL single_req got=%b exp=00001", bus.spc_pcx_req_pq);
    end
    advance();
    settle();
    checks++;
    if (bus.spc_pcx_data_pa !== 124'hA5 || bus.spc_pcx_req_pq !== 5'b0) begin
      failures++;
      $display("FAIL single_data got=%h req=%b exp=a5",
               bus.spc_pcx_data_pa, bus.spc_pcx_req_pq);
    end
    advance();
    settle();
    checks++;
    if (bus.spc_pcx_data_pa !== '0) begin
      failures++;
      $display("FAIL single_zero got=%h exp=0", bus.spc_pcx_data_pa);
    end
    advance();
  endtask

  task automatic test_credits();
    logic [ND-1:0] er;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      idle_in();
      if (c < 3) put(5'b00100, 1'b0, PW'(c + 1));
      if (c == 5) bus.pcx_spc_grant_pa = 5'b00100;
      er = (c == 1 || c == 2 || c == 6) ? 5'b00100 : 5'b0;
      settle();
      checks++;
      if (bus.spc_pcx_req_pq !== er) begin
        failures++;
        $display("FAIL credit_req c=%0d got=%b exp=%b", c,
                 bus.spc_pcx_req_pq, er);
      end
      if (c == 7) begin
        checks++;
        if (bus.spc_pcx_data_pa !== PW'(3)) begin
          failures++;
          $display("FAIL credit_data got=%h exp=3", bus.spc_pcx_data_pa);
        end
      end
      advance();
    end
  endtask

  task automatic test_stall();
    logic [ND-1:0] er;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      idle_in();
      if (c == 0) put(5'b01000, 1'b0, 124'h77);
      bus.pcx_stall_pq = (c >= 1 && c <= 3);
      er = (c == 4) ? 5'b01000 : 5'b0;
      settle();
      checks++;
      if (bus.spc_pcx_req_pq !== er) begin
        failures++;
        $display("FAIL stall_req c=%0d got=%b exp=%b", c,
                 bus.spc_pcx_req_pq, er);
      end
      if (c == 5) begin
        checks++;
        if (bus.spc_pcx_data_pa !== 124'h77) begin
          failures++;
          $display("FAIL stall_data got=%h exp=77", bus.spc_pcx_data_pa);
        end
      end
      advance();
    end
  endtask

  task automatic test_atomic();
    logic [ND-1:0] er;
    logic          ea;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      idle_in();
      if (c <= 3) put(5'b00010, c == 1, PW'(16 + c));
      if (c == 5) bus.pcx_spc_grant_pa = 5'b00010;
      if (c == 7) bus.pcx_stall_pq = 1'b1;
      er = (c == 1 || c == 6 || c == 7) ? 5'b00010 : 5'b0;
      ea = (c == 6);
      settle();
      checks++;
      if (bus.spc_pcx_req_pq !== er || bus.spc_pcx_atom_pq !== ea) begin
        failures++;
        $display("FAIL atom_req c=%0d got=%b/%b exp=%b/%b", c,
                 bus.spc_pcx_req_pq, bus.spc_pcx_atom_pq, er, ea);
      end
      if (c == 7 || c == 8) begin
        checks++;
        if (bus.spc_pcx_data_pa !== PW'(10 + c)) begin
          failures++;
          $display("FAIL atom_data c=%0d got=%h exp=%h", c,
                   bus.spc_pcx_data_pa, PW'(10 + c));
        end
      end
      advance();
    end
  endtask

  task automatic test_credit_err();
    logic [ND-1:0] er;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      idle_in();
      if (c <= 2) put(5'b10000, 1'b0, PW'(32 + c));
      if (c == 0) bus.pcx_spc_grant_pa = 5'b10000;
      er = (c == 1 || c == 2) ? 5'b10000 : 5'b0;
      settle();
      checks++;
      if (bus.pcx_credit_err !== (c != 0)) begin
        failures++;
        $display("FAIL cerr_flag c=%0d got=%b exp=%b", c,
                 bus.pcx_credit_err, c != 0);
      end
      checks++;
      if (bus.spc_pcx_req_pq !== er) begin
        failures++;
        $display("FAIL cerr_req c=%0d got=%b exp=%b", c,
                 bus.spc_pcx_req_pq, er);
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_atom();
    logic [ND-1:0] er;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      idle_in();
      if (c <= 1) put(5'b00001, c == 0, PW'(48 + c));
      rst_l = (c != 2);
      er = (c == 2) ? 5'b00001 : 5'b0;
      settle();
      checks++;
      if (bus.spc_pcx_req_pq !== er || bus.spc_pcx_atom_pq !== (c == 2)) begin
        failures++;
        $display("FAIL midrst_req c=%0d got=%b/%b exp=%b", c,
                 bus.spc_pcx_req_pq, bus.spc_pcx_atom_pq, er);
      end
      if (c == 3) begin
        checks++;
        if (bus.spc_pcx_data_pa !== '0) begin
          failures++;
          $display("FAIL midrst_data got=%h exp=0", bus.spc_pcx_data_pa);
        end
      end
      advance();
    end
    rst_l = 1'b1;
  endtask

  task automatic test_random();
    bit            need2;
    logic [ND-1:0] d2;
    logic [127:0]  r;
    bit            acc;
    do_reset();
    need2 = 0;
    d2 = '0;
    for (int c = 0; c < 800; c++) begin
      idle_in();
      bus.pcx_stall_pq = ($urandom % 5) == 0;
      bus.lsu_pcx_vld = ($urandom % 4) != 0;
      r = {$urandom, $urandom, $urandom, $urandom};
      bus.lsu_pcx_data = r[PW-1:0];
      if (need2) begin
        bus.lsu_pcx_dest = d2;
        bus.lsu_pcx_atom = 1'b0;
      end else begin
        bus.lsu_pcx_dest = ND'(1 << ($urandom % ND));
        bus.lsu_pcx_atom = ($urandom % 5) == 0;
      end
      for (int d = 0; d < ND; d++)
        bus.pcx_spc_grant_pa[d] = mout[d] > 0 && ($urandom % 3) == 0;
      settle();
      checks++;
      if (bus.spc_pcx_req_pq !== e_req || bus.spc_pcx_atom_pq !== e_atom) begin
        failures++;
        $display("FAIL rnd_req c=%0d got=%b/%b exp=%b/%b", c,
                 bus.spc_pcx_req_pq, bus.spc_pcx_atom_pq, e_req, e_atom);
      end
      checks++;
      if (bus.spc_pcx_data_pa !== mdata) begin
        failures++;
        $display("FAIL rnd_data c=%0d got=%h exp=%h", c,
                 bus.spc_pcx_data_pa, mdata);
      end
      checks++;
      if (bus.pcx_lsu_rdy !== (mq.size() < DP)) begin
        failures++;
        $display("FAIL rnd_rdy c=%0d got=%b exp=%b", c,
                 bus.pcx_lsu_rdy, mq.size() < DP);
      end
      checks++;
      if (bus.pcx_credit_err !== merr) begin
        failures++;
        $display("FAIL rnd_err c=%0d got=%b exp=%b", c,
                 bus.pcx_credit_err, merr);
      end
      acc = bus.lsu_pcx_vld && (mq.size() < DP);
      if (acc) begin
        need2 = !need2 && bus.lsu_pcx_atom;
        d2 = bus.lsu_pcx_dest;
      end
      advance();
    end
  endtask

  initial begin
    idle_in();
    m_reset();
    test_reset();
    test_single();
    test_credits();
    test_stall();
    test_atomic();
    test_credit_err();
    test_reset_mid_atom();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
